// File: rtl/lcd_bus_pkg.sv
// Shared types and register map for the LCD 8080-style bus controller.
// Build option: LCD_RST_CTRL_EN adds a software-driven panel reset pin.
package lcd_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } lcd_state_e;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_TIMING = 2'd3;

  localparam int TM_SETUP_LSB  = 0;
  localparam int TM_STROBE_LSB = 4;
  localparam int TM_HOLD_LSB   = 8;
  localparam int TM_RST_BIT    = 16;

  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_OVF_BIT   = 1;
  localparam int ST_LEVEL_LSB = 8;

endpackage

// File: rtl/lcd_bus_ctrl_fifo.sv
// Command/data word queue for the LCD controller.
// Registered storage, first-word-fall-through read port.
module lcd_cmd_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/system_qsys_lcd_bus_ctrl.sv
// Avalon-MM slave queueing LCD words and strobing them out on an 8080 bus.
// Build option: LCD_RST_CTRL_EN adds lcd_rst_n driven from TIMING[16].
module system_qsys_lcd_bus_ctrl
  import lcd_bus_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int DEF_SETUP  = 1,
  parameter int DEF_STROBE = 2,
  parameter int DEF_HOLD   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
`ifdef LCD_RST_CTRL_EN
  output logic              lcd_rst_n,
`endif
  output logic [DATA_W-1:0] lcd_data
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  lcd_state_e        state;
  lcd_state_e        nxt;
  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic [3:0]        tm_setup;
  logic [3:0]        tm_strobe;
  logic [3:0]        tm_hold;
  logic              rst_hold;
  logic              ovf;
  logic              wr_en;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic [DATA_W:0]   fifo_dout;
  logic              unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign push         = wr_en && !address[1];
  assign unused_wdata = ^writedata;

  lcd_cmd_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({address[0], writedata[DATA_W-1:0]}),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tm_setup  <= 4'(DEF_SETUP);
      tm_strobe <= 4'(DEF_STROBE);
      tm_hold   <= 4'(DEF_HOLD);
    end else if (wr_en && address == ADDR_TIMING) begin
      tm_setup  <= writedata[TM_SETUP_LSB  +: 4];
      tm_strobe <= writedata[TM_STROBE_LSB +: 4];
      tm_hold   <= writedata[TM_HOLD_LSB   +: 4];
    end
  end

`ifdef LCD_RST_CTRL_EN
  // Panel comes out of reset held; software releases it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rst_hold <= 1'b1;
    end else if (wr_en && address == ADDR_TIMING) begin
      rst_hold <= writedata[TM_RST_BIT];
    end
  end
  assign lcd_rst_n = ~rst_hold;
`else
  assign rst_hold = 1'b0;
`endif

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else begin
      ovf <= (push && full) ||
             (ovf && !(wr_en && address == ADDR_STATUS &&
                       writedata[ST_OVF_BIT]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !rst_hold) begin
          pop     = 1'b1;
          nxt     = SETUP;
          cnt_nxt = tm_setup;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          nxt     = STROBE;
          cnt_nxt = tm_strobe;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == '0) begin
          nxt     = HOLD;
          cnt_nxt = tm_hold;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 4'd1;
        end else if (!empty && !rst_hold) begin
          pop     = 1'b1;
          nxt     = SETUP;
          cnt_nxt = tm_setup;
        end else begin
          nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else if (pop) begin
      lcd_rs   <= fifo_dout[DATA_W];
      lcd_data <= fifo_dout[DATA_W-1:0];
    end
  end

  assign lcd_cs_n = (state == IDLE);
  assign lcd_wr_n = (state != STROBE);
  assign lcd_rd_n = 1'b1;

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      (address == ADDR_STATUS): begin
        readdata[ST_BUSY_BIT]       = (state != IDLE) || !empty;
        readdata[ST_OVF_BIT]        = ovf;
        readdata[ST_LEVEL_LSB +: 8] = 8'(level);
      end
      (address == ADDR_TIMING): begin
        readdata[TM_SETUP_LSB  +: 4] = tm_setup;
        readdata[TM_STROBE_LSB +: 4] = tm_strobe;
        readdata[TM_HOLD_LSB   +: 4] = tm_hold;
        readdata[TM_RST_BIT]         = rst_hold;
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_system_qsys_lcd_bus_ctrl.sv
// Bench for the LCD bus controller: word-level timeline model plus pinned cases.
// Build option: LCD_RST_CTRL_EN exercises the panel reset pin.
`timescale 1ns/1ps
module tb_system_qsys_lcd_bus_ctrl;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
`ifdef LCD_RST_CTRL_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          lcd_cs_n;
  logic          lcd_rs;
  logic          lcd_wr_n;
  logic          lcd_rd_n;
  logic [DW-1:0] lcd_data;
`ifdef LCD_RST_CTRL_EN
  logic          lcd_rst_n;
`endif

  int nvec = 0;
  int nmis = 0;
  int cyc  = 0;

  always #5 clk = ~clk;

  system_qsys_lcd_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .lcd_cs_n   (lcd_cs_n),
    .lcd_rs     (lcd_rs),
    .lcd_wr_n   (lcd_wr_n),
    .lcd_rd_n   (lcd_rd_n),
`ifdef LCD_RST_CTRL_EN
    .lcd_rst_n  (lcd_rst_n),
`endif
    .lcd_data   (lcd_data)
  );

  // Model: queue of words plus a per-word timeline snapshot.
  logic [DW:0] mq [$];
  logic [DW:0] m_word = '0;
  bit          m_ok = 0;
  bit          m_act = 0;
  bit          m_ovf = 0;
  bit          m_rsth = 0;
  int          m_off = 0;
  int          m_len = 0;
  int          m_s1 = 0;
  int          m_t1 = 0;
  logic [3:0]  m_su = 4'd1;
  logic [3:0]  m_st = 4'd2;
  logic [3:0]  m_ho = 4'd1;

  function automatic bit m_busy();
    return m_act || (mq.size() > 0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    logic [31:0] v;
    v = '0;
    if (a == 2'd2) begin
      v[0]    = m_busy();
      v[1]    = m_ovf;
      v[15:8] = 8'(mq.size());
    end else if (a == 2'd3) begin
      v[11:0] = {m_ho, m_st, m_su};
      v[16]   = m_rsth;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    int sz;
    bit wr;
    cyc++;
    wr = chipselect && !write_n;
    if (reset) begin
      mq.delete();
      m_act  = 0;
      m_ovf  = 0;
      m_su   = 4'd1;
      m_st   = 4'd2;
      m_ho   = 4'd1;
      m_rsth = RST_EN;
      m_word = '0;
      m_ok   = 1;
    end else if (m_ok) begin
      sz = mq.size();
      if (m_act) begin
        m_off++;
        if (m_off == m_len) m_act = 0;
      end
      if (!m_act && sz > 0 && !m_rsth) begin
        m_word = mq.pop_front();
        m_act  = 1;
        m_off  = 0;
        m_s1   = m_su + 1;
        m_t1   = m_st + 1;
        m_len  = m_su + m_st + m_ho + 3;
      end
      if (wr && address == 2'd2 && writedata[1]) m_ovf = 0;
      if (wr && address <= 2'd1) begin
        if (sz == DEPTH) m_ovf = 1;
        else mq.push_back({address[0], writedata[DW-1:0]});
      end
      if (wr && address == 2'd3) begin
        m_su = writedata[3:0];
        m_st = writedata[7:4];
        m_ho = writedata[11:8];
        if (RST_EN) m_rsth = writedata[16];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    bit strobe;
    #1;
    if (m_ok) begin
      strobe = m_act && m_off >= m_s1 && m_off < m_s1 + m_t1;
      chk("cs_n", lcd_cs_n, !m_act);
      chk("wr_n", lcd_wr_n, !strobe);
      chk("rd_n", lcd_rd_n, 1);
      chk("rs", lcd_rs, m_word[DW]);
      chk("data", lcd_data, m_word[DW-1:0]);
      chk("readdata", readdata, exp_rd(address));
`ifdef LCD_RST_CTRL_EN
      chk("rst_n", lcd_rst_n, !m_rsth);
`endif
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (m_busy() && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (m_busy()) begin
      nvec++;
      nmis++;
      $display("FAIL idle_wait: still busy after %0d cycles", budget);
    end
  endtask

  logic cs_exp [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
  logic wr_exp [9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};

  initial begin
    int falls [$];
    int rises;
    int nstr;
    bit pw;
    bit pc;
    logic [31:0] tv;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    address = 2'd3;
    #1;
    chk("t1_timing", readdata, RST_EN ? 32'h0001_0121 : 32'h0000_0121);
    address = 2'd2;
    #1;
    chk("t1_status", readdata, 32'h0);
    chk("t1_cs", lcd_cs_n, 1);
    chk("t1_wr", lcd_wr_n, 1);
    @(negedge clk);

`ifdef LCD_RST_CTRL_EN
    chk("t6_rst_held", lcd_rst_n, 0);
    wr(2'd0, 32'h55);
    for (int i = 0; i < 8; i++) begin
      chk("t6_no_cs", lcd_cs_n, 1);
      @(negedge clk);
    end
    wr(2'd3, 32'h121);
    chk("t6_rst_rel", lcd_rst_n, 1);
    @(negedge clk);
    chk("t6_drain_cs", lcd_cs_n, 0);
    wait_idle(50);
    @(negedge clk);
`endif

    wr(2'd0, 32'h002C);
    for (int i = 0; i < 9; i++) begin
      chk("t2_cs", lcd_cs_n, cs_exp[i]);
      chk("t2_wr", lcd_wr_n, wr_exp[i]);
      if (!cs_exp[i]) begin
        chk("t2_data", lcd_data, 32'h2C);
        chk("t2_rs", lcd_rs, 0);
      end
      @(negedge clk);
    end

    wr(2'd1, 32'hF800);
    wr(2'd1, 32'h07E0);
    rises = 0;
    pw = lcd_wr_n;
    pc = lcd_cs_n;
    for (int i = 0; i < 30; i++) begin
      if (pw && !lcd_wr_n) begin
        falls.push_back(i);
        chk("t3_rs", lcd_rs, 1);
      end
      if (!pc && lcd_cs_n) rises++;
      pw = lcd_wr_n;
      pc = lcd_cs_n;
      @(negedge clk);
    end
    chk("t3_pulses", falls.size(), 2);
    if (falls.size() == 2) chk("t3_gap", falls[1] - falls[0], 7);
    chk("t3_cs_rises", rises, 1);
    address = 2'd2;
    #1;
    chk("t3_busy", readdata[0], 0);
    @(negedge clk);

    wr(2'd3, 32'h0);
    wait_idle(20);
    for (int i = 0; i < 17; i++) wr(2'(i & 1), 32'h100 + i);
    address = 2'd2;
    #1;
    chk("t4_status", readdata, 32'h0000_0B01);
    wait_idle(200);
    @(negedge clk);
    wr(2'd3, 32'hFFF);
    for (int i = 0; i < 20; i++) wr(2'd1, 32'h200 + i);
    address = 2'd2;
    #1;
    chk("t4_ovf", readdata, 32'h0000_1003);
    @(negedge clk);
    wr(2'd2, 32'h2);
    address = 2'd2;
    #1;
    chk("t4_clr", readdata, 32'h0000_1001);
    @(negedge clk);

    for (int i = 0; i < 200 && lcd_wr_n; i++) @(negedge clk);
    chk("t5_in_strobe", lcd_wr_n, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    address = 2'd2;
    #1;
    chk("t5_wr", lcd_wr_n, 1);
    chk("t5_cs", lcd_cs_n, 1);
    chk("t5_status", readdata, 32'h0);
    nstr = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!lcd_wr_n) nstr++;
    end
    chk("t5_no_strobe", nstr, 0);
`ifdef LCD_RST_CTRL_EN
    wr(2'd3, 32'h121);
`endif

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 199);
      if (r < 90) begin
        wr(2'($urandom_range(0, 1)), $urandom);
      end else if (r < 100) begin
        wr(2'd2, $urandom);
      end else if (r < 108 && !m_act && (mq.size() == 0 || m_rsth)) begin
        tv = $urandom & 32'h0001_0333;
        if ($urandom_range(0, 3) != 0) tv[16] = 1'b0;
        wr(2'd3, tv);
      end else if (r == 199) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        address = 2'($urandom_range(0, 3));
        @(negedge clk);
      end
      address = 2'($urandom_range(0, 3));
    end
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
